// File: rtl/sdc_blk_fetch.sv
// Block fetch engine behind the ADMA2 FSM: owns the system address register and
// copies one block from system RAM into the data-line transmit FIFO per start strobe.
module sdc_blk_fetch #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BLK_BYTES = 512,
   parameter int RAM_LAT   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sar_load_strb,
   input  logic [ADDR_W-1:0] sar_load_val,
   input  logic              adma_sar_inc_strb,
   input  logic              strt_fifo_strb,
   input  logic              xfer_abort,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_wr_data,
   input  logic              fifo_full,
   input  logic              blk_sent_strb,
   output logic              dat_tf_done,
   output logic              busy,
   output logic [ADDR_W-1:0] cur_sar,
   output logic              sar_err,
   output logic [2:0]        state_dbg
);

   localparam int BPW   = DATA_W / 8;
   localparam int WPB   = BLK_BYTES / BPW;
   localparam int CNT_W = $clog2(WPB + 1);

   localparam logic [CNT_W-1:0]  WPB_C   = CNT_W'(WPB);
   localparam logic [ADDR_W-1:0] BLK_INC = ADDR_W'(BLK_BYTES);
   localparam logic [ADDR_W-1:0] BPW_INC = ADDR_W'(BPW);
   localparam logic [2:0]        LAT_C   = 3'(RAM_LAT);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_RD   = 3'd2,
      PUSH      = 3'd3,
      WAIT_SENT = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] sar;
   logic [ADDR_W-1:0] blk_base;
   logic [DATA_W-1:0] hold;
   logic [CNT_W-1:0]  word_cnt;
   logic [CNT_W-1:0]  word_nxt;
   logic [2:0]        lat_cnt;
   logic              sent;
   logic              sar_strb;

   // FIFO handshake: a word is transferred in every cycle where fifo_wr_en is high;
   // fifo_wr_en is only raised in a cycle where fifo_full is low, and the word is
   // held unchanged in PUSH for as long as fifo_full stays high.
   assign busy         = (state != IDLE);
   assign ram_rd_en    = (state == ISSUE) && !xfer_abort;
   assign fifo_wr_en   = (state == PUSH) && !fifo_full && !xfer_abort;
   assign fifo_wr_data = hold;
   assign cur_sar      = sar;
   assign state_dbg    = state;
   assign word_nxt     = word_cnt + CNT_W'(1);
   assign sar_strb     = sar_load_strb || adma_sar_inc_strb;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         sar         <= '0;
         blk_base    <= '0;
         ram_addr    <= '0;
         hold        <= '0;
         word_cnt    <= '0;
         lat_cnt     <= '0;
         sent        <= 1'b0;
         dat_tf_done <= 1'b0;
         sar_err     <= 1'b0;
      end else begin
         dat_tf_done <= 1'b0;
         sar_err     <= busy && sar_strb;

         if (busy && xfer_abort) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (sar_load_strb) begin
                     sar <= sar_load_val;
                  end else if (adma_sar_inc_strb) begin
                     blk_base <= sar;
                     sar      <= sar + BLK_INC;
                  end
                  if (strt_fifo_strb) begin
                     state    <= ISSUE;
                     word_cnt <= '0;
                     sent     <= 1'b0;
                     ram_addr <= blk_base;
                  end
               end
               ISSUE: begin
                  lat_cnt <= LAT_C;
                  state   <= WAIT_RD;
               end
               WAIT_RD: begin
                  // Counter reaching zero marks the cycle the read data is valid.
                  lat_cnt <= lat_cnt - 3'd1;
                  if (lat_cnt == 3'd1) begin
                     hold  <= ram_rd_data;
                     state <= PUSH;
                  end
               end
               PUSH: begin
                  if (!fifo_full) begin
                     word_cnt <= word_nxt;
                     ram_addr <= ram_addr + BPW_INC;
                     state    <= (word_nxt == WPB_C) ? WAIT_SENT : ISSUE;
                  end
               end
               WAIT_SENT: begin
                  if (sent) begin
                     state       <= DONE;
                     dat_tf_done <= 1'b1;
                  end
               end
               DONE: begin
                  sent  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase

            // Remember an early sent strobe so it is not lost before WAIT_SENT.
            if (busy && blk_sent_strb && state != DONE) sent <= 1'b1;
         end
      end
   end

endmodule
